// File: rtl/moore_seqgen_pkg.sv
// -----------------------------------------------------------------------------
// moore_seqgen_pkg
//   Shared definitions for the serial pattern generator and its benches:
//   the FSM state encoding, the default pattern, a packed view of the four
//   outputs, and the busy-length formula used when sizing scoreboards.
// -----------------------------------------------------------------------------
package moore_seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // Output bundle in port order {t, t_valid, busy, done}.
  typedef struct packed {
    logic t;
    logic t_valid;
    logic busy;
    logic done;
  } seq_out_t;

  // Number of cycles busy is high for one accepted start, DONE included.
  function automatic int unsigned busy_cycles(input int unsigned rep,
                                              input int unsigned pat_w,
                                              input int unsigned gap_len);
    if (rep == 0) return 1;
    return rep * pat_w + (rep - 1) * gap_len + 1;
  endfunction

endpackage

// File: rtl/seqgen_shreg.sv
// -----------------------------------------------------------------------------
// seqgen_shreg
//   Parallel-load, shift-left register with a zero fill. The MSB is the
//   serial output; once every loaded bit has been shifted out the register
//   holds all zeros, so its MSB is 0 whenever no pattern is in flight.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (clears to zero)
//   load       : load din (takes priority over shift)
//   shift      : shift left by one, zero into the LSB
//   din        : parallel load value
//   msb        : current MSB
// -----------------------------------------------------------------------------
module seqgen_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] q;

  // NOTE: this register is reset even though it is pure datapath, because
  // its MSB drives the serial output directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = q[PAT_W-1];

endmodule

// File: rtl/moore_seqgen.sv
// -----------------------------------------------------------------------------
// moore_seqgen
//   Serial pattern generator. An accepted start emits PATTERN MSB-first,
//   repeat_n times, with gap zero bits between repetitions, then pulses done
//   for one cycle. Every output comes straight from a flop.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, only sampled in IDLE
//   repeat_n   : repetition count, latched on an accepted start (0 = none)
//   gap        : zero bits between repetitions, latched on an accepted start
//   t          : serial bit stream
//   t_valid    : t carries a pattern or gap bit
//   busy       : from the cycle after an accepted start through DONE
//   done       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module moore_seqgen
  import moore_seqgen_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             t,
  output logic             t_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  state_e           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;   // repetitions left, current one included
  logic [GAP_W-1:0] gap_len;   // latched gap length
  logic [GAP_W-1:0] gap_cnt;   // gap cycles left, current one included

  logic accept;
  logic last_bit;
  logic final_rep;
  logic gap_end;
  logic load;
  logic shift;

  // NOTE: every signal in this block is assigned on every pass, so the
  // block stays purely combinational and no latch can be inferred.
  always_comb begin
    accept    = (state == IDLE) && start;
    last_bit  = (state == SEND) && (bit_cnt == LAST_BIT);
    final_rep = (rep_cnt == CNT_W'(1));
    gap_end   = (state == GAP) && (gap_cnt == GAP_W'(1));
    // Reload on every entry to SEND: from IDLE, back-to-back, or after a gap.
    load      = (accept && (repeat_n != '0))
             || (last_bit && !final_rep && (gap_len == '0))
             || gap_end;
    // Shifting on the last bit too leaves the register all-zero, which
    // keeps t low in GAP, DONE and IDLE without extra gating.
    shift     = (state == SEND);
  end

  seqgen_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (PATTERN),
    .msb   (t)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_len <= '0;
      gap_cnt <= '0;
      t_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rep_cnt <= repeat_n;
            gap_len <= gap;
            bit_cnt <= '0;
            busy    <= 1'b1;
            if (repeat_n != '0) begin
              state   <= SEND;
              t_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (last_bit) begin
            bit_cnt <= '0;
            rep_cnt <= rep_cnt - CNT_W'(1);
            if (final_rep) begin
              state   <= DONE;
              t_valid <= 1'b0;
              done    <= 1'b1;
            end else if (gap_len != '0) begin
              state   <= GAP;
              gap_cnt <= gap_len;
            end
            // Otherwise stay in SEND; the shift register reloads this edge.
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end

        GAP: begin
          if (gap_end) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seqgen.sv
// -----------------------------------------------------------------------------
// tb_moore_seqgen
//   Scoreboard bench for moore_seqgen. Each stream pushes its expected
//   per-cycle {t, t_valid, busy, done} words when start is driven; a monitor
//   pops one word per cycle, just after the rising edge, and compares.
// -----------------------------------------------------------------------------
module tb_moore_seqgen;
  import moore_seqgen_pkg::*;

  localparam int               PAT_W   = DEF_PAT_W;
  localparam logic [PAT_W-1:0] PATTERN = DEF_PATTERN;
  localparam int               CNT_W   = 8;
  localparam int               GAP_W   = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic [GAP_W-1:0] gap      = '0;
  logic             t;
  logic             t_valid;
  logic             busy;
  logic             done;

  int       vectors     = 0;
  int       miscompares = 0;
  int       busy_seen   = 0;
  seq_out_t exp_q[$];
  seq_out_t mon_exp;
  seq_out_t obs;

  always #5 clk = ~clk;

  moore_seqgen #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W),
    .GAP_W   (GAP_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .repeat_n (repeat_n),
    .gap      (gap),
    .t        (t),
    .t_valid  (t_valid),
    .busy     (busy),
    .done     (done)
  );

  assign obs = seq_out_t'({t, t_valid, busy, done});

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic seq_out_t mk(input logic tb, input logic v,
                                  input logic b, input logic d);
    return seq_out_t'({tb, v, b, d});
  endfunction

  // Expected stream for one accepted start, followed by one IDLE cycle.
  function automatic void push_stream(input int rep, input int gp);
    for (int r = 0; r < rep; r++) begin
      for (int b = 0; b < PAT_W; b++)
        exp_q.push_back(mk(PATTERN[PAT_W-1-b], 1'b1, 1'b1, 1'b0));
      if (r < rep - 1)
        for (int g = 0; g < gp; g++)
          exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
  endfunction

  // Monitor: one comparison per cycle while expectations are queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check($sformatf("out[%0d] tvbd", vectors), 32'(obs), 32'(mon_exp));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Start a stream; start is re-pulsed in cycles p1/p2 (0 = never) and the
  // repeat_n/gap inputs are scrambled after acceptance.
  task automatic run_stream(input int rep, input int gp,
                            input int p1, input int p2);
    int total;
    total = int'(busy_cycles(rep, PAT_W, gp));
    @(negedge clk);
    repeat_n  = CNT_W'(rep);
    gap       = GAP_W'(gp);
    start     = 1'b1;
    busy_seen = 0;
    push_stream(rep, gp);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      start    = (k == p1) || (k == p2);
      repeat_n = CNT_W'($urandom);
      gap      = GAP_W'($urandom);
    end
    start = 1'b0;
    drain();
    check($sformatf("busy_len rep=%0d gap=%0d", rep, gp), 32'(busy_seen),
          32'(total));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, before and after clock edges.
    #1;
    check("reset_pre_clk", 32'(obs), 32'd0);
    #20;
    check("reset_held", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 32'(obs), 32'd0);

    // Single repetition.
    run_stream(1, 0, 0, 0);
    // Three repetitions with a two-bit gap; start re-pulsed in SEND and GAP.
    run_stream(3, 2, 2, 6);
    // Back-to-back repetitions, start re-pulsed on the last bit.
    run_stream(2, 0, 4, 0);
    // Zero repetitions: DONE only.
    run_stream(0, 5, 0, 0);
    // Start immediately again from IDLE, maximum gap.
    run_stream(2, 15, 0, 0);

    // Asynchronous reset mid-SEND.
    @(negedge clk);
    repeat_n = CNT_W'(5);
    gap      = GAP_W'(1);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_send_cycle2", 32'(obs), 32'(mk(PATTERN[PAT_W-2], 1'b1, 1'b1, 1'b0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    run_stream(1, 0, 0, 0);

    // Largest repetition count must complete without counter wrap.
    run_stream(255, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
